// File: rtl/gray_rr_sched.sv
// rtl/gray_rr_sched.sv - round-robin requester scheduler capturing a binary operand and its Gray code
// Optional transaction counter enabled by macro GRAY_RR_SCHED_CNT_EN.
module gray_rr_sched #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req_valid,
    input  logic [4*WIDTH-1:0] req_data,
    output logic [3:0]         req_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_bin,
    output logic [WIDTH-1:0]   out_gray,
    output logic [1:0]         out_src,
`ifdef GRAY_RR_SCHED_CNT_EN
    output logic [7:0]         txn_count,
`endif
    output logic               busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_found;
    logic [1:0] scan_idx;
    logic [WIDTH-1:0] sel_bin;

    // Scan upward from ptr with wrap; first asserted request wins.
    always_comb begin
        grant       = 4'b0000;
        grant_idx   = 2'd0;
        grant_found = 1'b0;
        scan_idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr + 2'(k);
            if (!grant_found && req_valid[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
                grant_found     = 1'b1;
            end
        end
    end

    assign sel_bin   = req_data[grant_idx*WIDTH +: WIDTH];
    assign req_ready = (state == IDLE) ? grant : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_bin   <= '0;
            out_gray  <= '0;
            out_src   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_bin   <= sel_bin;
                        out_gray  <= sel_bin ^ (sel_bin >> 1);
                        out_src   <= grant_idx;
                    end
                end
                HOLD: begin
                    // No new grant on the handshake edge; the next pick starts after the owner.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        ptr       <= out_src + 2'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef GRAY_RR_SCHED_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= 8'd0;
        end else if (state == HOLD && out_ready) begin
            txn_count <= txn_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_rr_sched.sv
// tb/tb_gray_rr_sched.sv - table-driven and directed checks for gray_rr_sched
module tb_gray_rr_sched;

    localparam int WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [3:0]         req_valid = 4'b0000;
    logic [4*WIDTH-1:0] req_data = '0;
    logic [3:0]         req_ready;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [WIDTH-1:0]   out_bin;
    logic [WIDTH-1:0]   out_gray;
    logic [1:0]         out_src;
    logic               busy;
`ifdef GRAY_RR_SCHED_CNT_EN
    logic [7:0]         txn_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_rr_sched #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_gray  (out_gray),
        .out_src   (out_src),
`ifdef GRAY_RR_SCHED_CNT_EN
        .txn_count (txn_count),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [3:0]  rv;
        logic [15:0] data;
        logic        ordy;
        logic [3:0]  rr;
        logic        ov;
        logic [3:0]  gray;
        logic [1:0]  src;
    } vec_t;

    vec_t vecs[20];
    logic [3:0] gray_exp[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_data  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_bin", 32'(out_bin), 32'd0);
        chk("rst_out_gray", 32'(out_gray), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
`ifdef GRAY_RR_SCHED_CNT_EN
        chk("rst_txn_count", 32'(txn_count), 32'd0);
`endif
    endtask

    initial begin
        // Rotation with all requesters valid, then single-requester and skip cases.
        vecs[0]  = '{4'b1111, 16'h3219, 1'b1, 4'b0001, 1'b0, 4'h0, 2'd0};
        vecs[1]  = '{4'b1111, 16'h3219, 1'b1, 4'b0000, 1'b1, 4'b1101, 2'd0};
        vecs[2]  = '{4'b1111, 16'h3219, 1'b1, 4'b0010, 1'b0, 4'h0, 2'd0};
        vecs[3]  = '{4'b1111, 16'h3219, 1'b1, 4'b0000, 1'b1, 4'b0001, 2'd1};
        vecs[4]  = '{4'b1111, 16'h3219, 1'b1, 4'b0100, 1'b0, 4'h0, 2'd0};
        vecs[5]  = '{4'b1111, 16'h3219, 1'b1, 4'b0000, 1'b1, 4'b0011, 2'd2};
        vecs[6]  = '{4'b1111, 16'h3219, 1'b1, 4'b1000, 1'b0, 4'h0, 2'd0};
        vecs[7]  = '{4'b1111, 16'h3219, 1'b1, 4'b0000, 1'b1, 4'b0010, 2'd3};
        vecs[8]  = '{4'b1111, 16'h3219, 1'b1, 4'b0001, 1'b0, 4'h0, 2'd0};
        vecs[9]  = '{4'b1111, 16'h3219, 1'b1, 4'b0000, 1'b1, 4'b1101, 2'd0};
        vecs[10] = '{4'b1111, 16'h3219, 1'b1, 4'b0010, 1'b0, 4'h0, 2'd0};
        vecs[11] = '{4'b1111, 16'h3219, 1'b1, 4'b0000, 1'b1, 4'b0001, 2'd1};
        vecs[12] = '{4'b0001, 16'h000B, 1'b1, 4'b0001, 1'b0, 4'h0, 2'd0};
        vecs[13] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 4'b1110, 2'd0};
        vecs[14] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0};
        vecs[15] = '{4'b0100, 16'h0000, 1'b1, 4'b0100, 1'b0, 4'h0, 2'd0};
        vecs[16] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd2};
        vecs[17] = '{4'b1010, 16'h5000, 1'b1, 4'b1000, 1'b0, 4'h0, 2'd0};
        vecs[18] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 4'b0111, 2'd3};
        vecs[19] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0};

        gray_exp = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        do_reset();

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req_valid = vecs[i].rv;
            req_data  = vecs[i].data;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].rr));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].ov));
            if (vecs[i].ov) begin
                chk($sformatf("vec%0d_out_gray", i), 32'(out_gray), 32'(vecs[i].gray));
                chk($sformatf("vec%0d_out_src", i), 32'(out_src), 32'(vecs[i].src));
            end
        end

        // Requester 2 sweeps all binary values.
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            req_valid = 4'b0100;
            req_data  = 16'(v) << 8;
            out_ready = 1'b1;
            #1;
            chk($sformatf("sweep%0d_req_ready", v), 32'(req_ready), 32'h4);
            @(negedge clk);
            req_valid = 4'b0000;
            req_data  = 16'hFFFF;
            #1;
            chk($sformatf("sweep%0d_out_valid", v), 32'(out_valid), 32'd1);
            chk($sformatf("sweep%0d_out_gray", v), 32'(out_gray), 32'(gray_exp[v]));
            chk($sformatf("sweep%0d_out_bin", v), 32'(out_bin), 32'(v));
            chk($sformatf("sweep%0d_out_src", v), 32'(out_src), 32'd2);
        end

        // Back-pressure in HOLD: ptr is 3, so requester 3 wins; later grant wraps to 0.
        @(negedge clk);
        req_valid = 4'b1111;
        req_data  = 16'hA000;
        out_ready = 1'b0;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h8);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_data = 16'($urandom);
            #1;
            chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'h0);
            chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_out_bin", c), 32'(out_bin), 32'hA);
            chk($sformatf("bp%0d_out_gray", c), 32'(out_gray), 32'hF);
            chk($sformatf("bp%0d_out_src", c), 32'(out_src), 32'd3);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_valid", 32'(out_valid), 32'd1);
        chk("bp_release_req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("bp_next_grant", 32'(req_ready), 32'h1);
        chk("bp_idle_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset while holding requester 0's result.
        @(negedge clk);
        #1;
        chk("pre_rst_hold", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_out_src", 32'(out_src), 32'd0);
        chk("async_rst_out_gray", 32'(out_gray), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1010;
        req_data  = 16'h00C0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("post_rst_src", 32'(out_src), 32'd1);
        chk("post_rst_bin", 32'(out_bin), 32'hC);

`ifdef GRAY_RR_SCHED_CNT_EN
        do_reset();
        for (int t = 0; t < 257; t++) begin
            @(negedge clk);
            req_valid = 4'b0001;
            out_ready = 1'b1;
            @(negedge clk);
            req_valid = 4'b0000;
        end
        @(negedge clk);
        #1;
        chk("txn_count_wrap", 32'(txn_count), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_rr_sched.md
GRAY_RR_SCHED -- requirements
Module: gray_rr_sched

Interface
REQ-001 The block SHALL have this parameter: WIDTH, 4, bit width of each binary operand and of the Gray result.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port req_valid, input, 4, per-requester request; requester i uses bit i.
REQ-005 The block SHALL have port req_data, input, 4*WIDTH, binary operands; requester i uses bits [i*WIDTH +: WIDTH].
REQ-006 The block SHALL have port req_ready, output, 4, one-hot accept strobe to the granted requester.
REQ-007 The block SHALL have port out_valid, output, 1, result available.
REQ-008 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-009 The block SHALL have port out_bin, output, WIDTH, captured binary operand.
REQ-010 The block SHALL have port out_gray, output, WIDTH, Gray code of out_bin.
REQ-011 The block SHALL have port out_src, output, 2, index of the requester that owns the result.
REQ-012 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have two states: IDLE (no result held) and HOLD (result held, out_valid=1).
REQ-014 In IDLE, selection SHALL be round-robin: scan the asserted req_valid bits starting at index ptr and going upward with wrap 3->0; the first asserted bit wins.
REQ-015 In IDLE, req_ready SHALL be combinational: exactly the winner's bit is set, or 4'b0000 if no request is pending; in HOLD, req_ready SHALL be 4'b0000.
REQ-016 A request transfer SHALL occur at the rising edge where req_valid[i] & req_ready[i]; on that edge out_bin, out_src and out_gray SHALL be registered and the state SHALL go to HOLD.
REQ-017 Register-load rule: out_gray[WIDTH-1] SHALL equal bin[WIDTH-1], and out_gray[k] SHALL equal bin[k+1] XOR bin[k] for k < WIDTH-1.
REQ-018 Latency SHALL be: out_valid high in the cycle after the request transfer.
REQ-019 In HOLD, out_bin, out_gray and out_src SHALL stay stable until out_valid & out_ready at a rising edge.
REQ-020 On that out_valid & out_ready edge, the state SHALL return to IDLE and ptr SHALL become (out_src+1) mod 4.
REQ-021 Maximum throughput SHALL be one result every 2 cycles; no new request SHALL be accepted in the cycle of the output handshake.
REQ-022 With all four requesters continuously valid, grants SHALL rotate 0,1,2,3,0,...; no requester waits more than 3 grants.
REQ-023 A requester that drops req_valid before it is granted SHALL be skipped, with no state change.
REQ-024 req_data SHALL be sampled only on the transfer edge.

Reset
REQ-025 When rst_n is low, the block SHALL asynchronously force: state=IDLE, ptr=0, out_valid=0, busy=0, out_bin=0, out_gray=0, out_src=0.
REQ-026 A reset asserted in HOLD SHALL discard the held result, with no out handshake occurring.
REQ-027 After rst_n deasserts, the first grant SHALL go to the lowest-indexed valid requester.

Configuration
REQ-028 When macro GRAY_RR_SCHED_CNT_EN is defined, the block SHALL add output port txn_count[7:0]: reset 0, incremented on each out handshake, wrapping 255->0.
REQ-029 When GRAY_RR_SCHED_CNT_EN is undefined, the txn_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover: single requester 0, req_data[3:0]=4'b1011, out_ready=1 -> req_ready=4'b0001 on the transfer cycle, next cycle out_valid=1, out_gray=4'b1110, out_src=0; IDLE one cycle later.
REQ-031 The bench SHALL cover: sweep requester 2 over binary 0..15 -> out_gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000.
REQ-032 The bench SHALL cover: all req_valid=4'b1111 held, out_ready=1 -> out_src sequence 0,1,2,3,0,1, one result every 2 cycles.
REQ-033 The bench SHALL cover: HOLD with out_ready=0 for 5 cycles, req_valid=4'b1111 -> outputs stable, req_ready=0 throughout; out_ready=1 -> next grant goes to out_src+1.
REQ-034 The bench SHALL cover: rst_n pulsed low mid-HOLD -> out_valid=0 immediately, with no clock edge; after release with req_valid=4'b1010 -> first grant to requester 1.
REQ-035 The bench SHALL cover, with GRAY_RR_SCHED_CNT_EN defined: 257 completed transactions -> txn_count=1.
